// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
//   slot_state_t : per-port response slot state
//   SRAM_*       : macro geometry the arbiter is built around
//   BWEB_IDLE    : bit-write-enable pattern that writes nothing
//   strb2bweb    : byte strobes (active-high) -> BWEB (active-low, per bit)
package sram_arb_pkg;

   localparam int SRAM_ADDR_W = 14;
   localparam int SRAM_DATA_W = 32;
   localparam int SRAM_STRB_W = SRAM_DATA_W / 8;

   localparam logic [SRAM_DATA_W-1:0] BWEB_IDLE = '1;

   typedef enum logic [1:0] {
      EMPTY,  // no undrained read data
      LIVE,   // response is on the macro Q pins this cycle
      HELD    // response parked in the hold register
   } slot_state_t;

   function automatic logic [SRAM_DATA_W-1:0] strb2bweb(input logic [SRAM_STRB_W-1:0] wstrb);
      logic [SRAM_DATA_W-1:0] bweb;
      for (int k = 0; k < SRAM_STRB_W; k++) begin
         bweb[8*k +: 8] = {8{~wstrb[k]}};
      end
      return bweb;
   endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// One requester port of the SRAM arbiter: single-word request channel plus
// read-response channel.
//   master : the requester (drives req_*, rsp_ready)
//   slave  : the arbiter   (drives req_ready, rsp_valid, rsp_rdata)
interface sram_port_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_wstrb;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_ready;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_rsp_slot.sv
// Per-port read-response slot: tracks one outstanding read and parks the
// macro output in a hold register when the consumer stalls, because the
// other port may reuse the macro and overwrite Q on the next cycle.
//   ACLK/ARESETn : clock, synchronous active-low reset
//   grant_rd     : a read for this port is issued to the macro this cycle
//   rsp_ready    : consumer accepts the response this cycle
//   q            : macro read data
//   rsp_valid    : response present
//   rsp_rdata    : response data (live Q or held copy)
//   slot_free    : no undrained response
module sram_rsp_slot
   import sram_arb_pkg::*;
#(
   parameter int DATA_W = SRAM_DATA_W
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              grant_rd,
   input  logic              rsp_ready,
   input  logic [DATA_W-1:0] q,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              slot_free
);

   slot_state_t       state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;

   // hold register is data only; it is never observed in EMPTY
   always_ff @(posedge ACLK) begin
      if (!ARESETn) state_q <= EMPTY;
      else          state_q <= state_d;
      hold_q <= hold_d;
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         EMPTY: if (grant_rd) state_d = LIVE;
         LIVE: begin
            if (rsp_ready) begin
               state_d = grant_rd ? LIVE : EMPTY;
            end else begin
               // Q may be clobbered by the next access of either port
               hold_d  = q;
               state_d = HELD;
            end
         end
         HELD: if (rsp_ready) state_d = grant_rd ? LIVE : EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      rsp_valid = ARESETn && (state_q != EMPTY);
      rsp_rdata = (state_q == HELD) ? hold_q : q;
      slot_free = (state_q == EMPTY);
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro.
// Drives the macro pins directly; reads return one cycle after grant.
//   ACLK/ARESETn        : clock, synchronous active-low reset
//   p0, p1              : requester ports (req/rsp channels)
//   CEB, WEB, BWEB, A, D: macro controls (active-low enables), address, wdata
//   Q                   : macro read data, valid the cycle after a read
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   sram_port_arbiter_if.slave p0,
   sram_port_arbiter_if.slave p1,
   output logic               CEB,
   output logic               WEB,
   output logic [DATA_W-1:0]  BWEB,
   output logic [ADDR_W-1:0]  A,
   output logic [DATA_W-1:0]  D,
   input  logic [DATA_W-1:0]  Q
);

   logic                           last_grant_q, last_grant_d;
   logic [1:0]                     req_valid, req_we, rsp_ready;
   logic [1:0][ADDR_W-1:0]         req_addr;
   logic [1:0][DATA_W-1:0]         req_wdata;
   logic [1:0][DATA_W/8-1:0]       req_wstrb;
   logic [1:0]                     slot_free, rsp_valid, elig, gnt;
   logic [1:0][DATA_W-1:0]         rsp_rdata;
   logic                           sel;

   assign req_valid = {p1.req_valid, p0.req_valid};
   assign req_we    = {p1.req_we,    p0.req_we};
   assign rsp_ready = {p1.rsp_ready, p0.rsp_ready};
   assign req_addr  = {p1.req_addr,  p0.req_addr};
   assign req_wdata = {p1.req_wdata, p0.req_wdata};
   assign req_wstrb = {p1.req_wstrb, p0.req_wstrb};

   assign p0.req_ready = gnt[0];
   assign p1.req_ready = gnt[1];
   assign p0.rsp_valid = rsp_valid[0];
   assign p1.rsp_valid = rsp_valid[1];
   assign p0.rsp_rdata = rsp_rdata[0];
   assign p1.rsp_rdata = rsp_rdata[1];

   for (genvar i = 0; i < 2; i++) begin : g_slot
      sram_rsp_slot #(.DATA_W(DATA_W)) u_slot (
         .ACLK      (ACLK),
         .ARESETn   (ARESETn),
         .grant_rd  (gnt[i] & ~req_we[i]),
         .rsp_ready (rsp_ready[i]),
         .q         (Q),
         .rsp_valid (rsp_valid[i]),
         .rsp_rdata (rsp_rdata[i]),
         .slot_free (slot_free[i])
      );
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) last_grant_q <= 1'b1;
      else          last_grant_q <= last_grant_d;
   end

   // A read may only issue if its slot drains this cycle at the latest;
   // writes never occupy the slot.
   always_comb begin
      elig = req_valid & (slot_free | req_we | rsp_ready);
      gnt  = '0;
      if (ARESETn) begin
         if (elig == 2'b11) gnt = last_grant_q ? 2'b01 : 2'b10;
         else               gnt = elig;
      end
      last_grant_d = last_grant_q;
      if      (gnt[0]) last_grant_d = 1'b0;
      else if (gnt[1]) last_grant_d = 1'b1;
   end

   always_comb begin
      sel  = gnt[1];
      CEB  = 1'b1;
      WEB  = 1'b1;
      BWEB = BWEB_IDLE;
      A    = '0;
      D    = '0;
      if (|gnt) begin
         CEB = 1'b0;
         A   = req_addr[sel];
         if (req_we[sel]) begin
            WEB  = 1'b0;
            D    = req_wdata[sel];
            BWEB = strb2bweb(req_wstrb[sel]);
         end
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

   localparam int AW = 14;
   localparam int DW = 32;

   logic          ACLK = 1'b0;
   logic          ARESETn = 1'b0;
   logic          CEB, WEB;
   logic [DW-1:0] BWEB, D, Q;
   logic [AW-1:0] A;

   sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
   sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

   sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .p0(if0), .p1(if1),
      .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .D(D), .Q(Q)
   );

   always #5 ACLK = ~ACLK;

   // requester drive
   logic          v[2], we[2], rr[2];
   logic [AW-1:0] ad[2];
   logic [DW-1:0] wd[2];
   logic [3:0]    ws[2];

   assign if0.req_valid = v[0];  assign if1.req_valid = v[1];
   assign if0.req_we    = we[0]; assign if1.req_we    = we[1];
   assign if0.req_addr  = ad[0]; assign if1.req_addr  = ad[1];
   assign if0.req_wdata = wd[0]; assign if1.req_wdata = wd[1];
   assign if0.req_wstrb = ws[0]; assign if1.req_wstrb = ws[1];
   assign if0.rsp_ready = rr[0]; assign if1.rsp_ready = rr[1];

   // macro behaviour: registered read, per-bit masked write
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge ACLK) begin
      if (!CEB) begin
         if (!WEB) mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
         else      Q <= mem[A];
      end
   end

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // reference model: word-level memory image, one response queue per port
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   logic [DW-1:0] rq0[$];
   logic [DW-1:0] rq1[$];
   int            mlast = 1;

   always @(negedge ACLK) begin : model
      logic          rdy[2], rv[2], pend[2], el[2];
      logic [DW-1:0] rd[2], fr[2], eb, nw;
      int            w;
      rdy[0] = if0.req_ready; rdy[1] = if1.req_ready;
      rv[0]  = if0.rsp_valid; rv[1]  = if1.rsp_valid;
      rd[0]  = if0.rsp_rdata; rd[1]  = if1.rsp_rdata;
      if (!ARESETn) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst_rdy%0d", p), 32'(rdy[p]), 0);
            chk($sformatf("rst_rv%0d", p), 32'(rv[p]), 0);
         end
         chk("rst_ceb", 32'(CEB), 1);
         chk("rst_web", 32'(WEB), 1);
         chk("rst_bweb", BWEB, 32'hFFFF_FFFF);
         chk("rst_a", 32'(A), 0);
         chk("rst_d", D, 0);
         rq0.delete(); rq1.delete();
         mlast = 1;
      end else begin
         pend[0] = rq0.size() != 0;
         pend[1] = rq1.size() != 0;
         fr[0]   = pend[0] ? rq0[0] : '0;
         fr[1]   = pend[1] ? rq1[0] : '0;
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("rv%0d", p), 32'(rv[p]), 32'(pend[p]));
            if (pend[p]) chk($sformatf("rdata%0d", p), rd[p], fr[p]);
            el[p] = v[p] && (!pend[p] || we[p] || rr[p]);
         end
         if (el[0] && el[1]) w = 1 - mlast;
         else if (el[0])     w = 0;
         else if (el[1])     w = 1;
         else                w = -1;
         for (int p = 0; p < 2; p++)
            chk($sformatf("rdy%0d", p), 32'(rdy[p]), 32'(w == p));
         if (pend[0] && rr[0]) void'(rq0.pop_front());
         if (pend[1] && rr[1]) void'(rq1.pop_front());
         if (w >= 0) begin
            chk("ceb", 32'(CEB), 0);
            chk("addr", 32'(A), 32'(ad[w]));
            chk("web", 32'(WEB), 32'(!we[w]));
            if (we[w]) begin
               nw = shadow[ad[w]];
               for (int k = 0; k < 4; k++) begin
                  eb[8*k +: 8] = ws[w][k] ? 8'h00 : 8'hFF;
                  if (ws[w][k]) nw[8*k +: 8] = wd[w][8*k +: 8];
               end
               chk("d", D, wd[w]);
               chk("bweb", BWEB, eb);
               shadow[ad[w]] = nw;
            end else begin
               chk("bweb_rd", BWEB, 32'hFFFF_FFFF);
               if (w == 0) rq0.push_back(shadow[ad[w]]);
               else        rq1.push_back(shadow[ad[w]]);
            end
            mlast = w;
         end else begin
            chk("idle_ceb", 32'(CEB), 1);
            chk("idle_web", 32'(WEB), 1);
            chk("idle_bweb", BWEB, 32'hFFFF_FFFF);
            chk("idle_a", 32'(A), 0);
            chk("idle_d", D, 0);
         end
      end
   end

   task automatic step();
      @(posedge ACLK); #1;
   endtask

   task automatic mid();
      @(negedge ACLK); #1;
   endtask

   task automatic preload(input int a, input logic [DW-1:0] val);
      mem[a] = val;
      shadow[a] = val;
   endtask

   function automatic logic rdy_of(input int p);
      return (p == 0) ? if0.req_ready : if1.req_ready;
   endfunction

   // issue one request and hold it until accepted (bounded)
   task automatic req(input int p, input logic w, input int a,
                      input logic [DW-1:0] d, input logic [3:0] s);
      v[p] = 1'b1; we[p] = w; ad[p] = AW'(a); wd[p] = d; ws[p] = s;
      for (int n = 0; n < 20; n++) begin
         mid();
         if (rdy_of(p)) begin
            step();
            v[p] = 1'b0;
            return;
         end
         step();
      end
      chk("req_timeout", 32'(rdy_of(p)), 1);
      v[p] = 1'b0;
   endtask

   initial begin
      logic prev;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = '0;
         shadow[i] = '0;
      end
      Q = '0;
      for (int p = 0; p < 2; p++) begin
         v[p] = 0; we[p] = 0; rr[p] = 1; ad[p] = '0; wd[p] = '0; ws[p] = '0;
      end
      repeat (3) @(posedge ACLK);
      #1 ARESETn = 1'b1;
      step();

      // single read
      preload(5, 32'h0000_1234);
      v[0] = 1; we[0] = 0; ad[0] = 5;
      mid(); chk("sr_rdy", 32'(if0.req_ready), 1);
      step(); v[0] = 0;
      mid();
      chk("sr_rv", 32'(if0.rsp_valid), 1);
      chk("sr_data", if0.rsp_rdata, 32'h0000_1234);
      chk("sr_ceb", 32'(CEB), 1);
      step();

      // conflict: both read every cycle, grants alternate
      v[0] = 1; v[1] = 1; we[0] = 0; we[1] = 0; ad[0] = 1; ad[1] = 2;
      prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mid();
         chk("cf_one", 32'(if0.req_ready ^ if1.req_ready), 1);
         if (i > 0) chk("cf_alt", 32'(if0.req_ready), 32'(!prev));
         prev = if0.req_ready;
         step();
      end
      v[0] = 0; v[1] = 0;
      step();

      // stall/hold
      rr[0] = 0; v[0] = 1; we[0] = 0; ad[0] = 5;
      mid(); chk("st_gnt", 32'(if0.req_ready), 1);
      step();
      ad[0] = 7;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: begin v[1] = 1; we[1] = 1; ad[1] = 6; wd[1] = 32'hDEAD_BEEF; ws[1] = 4'hF; end
            1: begin v[1] = 1; we[1] = 0; ad[1] = 6; end
            default: v[1] = 0;
         endcase
         mid();
         chk("st_rv", 32'(if0.rsp_valid), 1);
         chk("st_hold", if0.rsp_rdata, 32'h0000_1234);
         chk("st_blk", 32'(if0.req_ready), 0);
         if (i == 2) chk("st_p1", if1.rsp_rdata, 32'hDEAD_BEEF);
         step();
      end
      rr[0] = 1;
      mid(); chk("st_release", 32'(if0.req_ready), 1);
      step(); v[0] = 0;
      step();

      // byte strobes
      req(0, 1, 3, 32'hFFFF_FFFF, 4'hF);
      req(0, 1, 3, 32'h1122_3344, 4'b0101);
      req(0, 0, 3, 32'h0, 4'h0);
      mid();
      chk("bs_rv", 32'(if0.rsp_valid), 1);
      chk("bs_data", if0.rsp_rdata, 32'hFF22_FF44);
      step();

      // back-to-back reads on port 1
      for (int i = 0; i < 8; i++) preload(i, 32'hC0DE_0000 + i);
      v[1] = 1; we[1] = 0;
      for (int i = 0; i < 8; i++) begin
         ad[1] = AW'(i);
         mid();
         chk("b2b_rdy", 32'(if1.req_ready), 1);
         if (i > 0) chk("b2b_data", if1.rsp_rdata, 32'hC0DE_0000 + 32'(i - 1));
         step();
      end
      v[1] = 0;
      mid(); chk("b2b_last", if1.rsp_rdata, 32'hC0DE_0007);
      step();

      // reset mid-read
      v[0] = 1; we[0] = 0; ad[0] = 5;
      mid(); chk("rm_gnt", 32'(if0.req_ready), 1);
      step(); v[0] = 0; ARESETn = 0;
      mid();
      chk("rm_rv", 32'(if0.rsp_valid), 0);
      chk("rm_ceb", 32'(CEB), 1);
      step(); ARESETn = 1;
      mid();
      chk("rm_rv_after0", 32'(if0.rsp_valid), 0);
      chk("rm_rv_after1", 32'(if1.rsp_valid), 0);
      step();

      // randomized traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            v[p]  = ($urandom_range(0, 1) == 1);
            we[p] = ($urandom_range(0, 9) < 4);
            ad[p] = AW'($urandom_range(0, 15));
            wd[p] = $urandom;
            ws[p] = 4'($urandom_range(0, 15));
            rr[p] = ($urandom_range(0, 3) != 0);
         end
         ARESETn = ($urandom_range(0, 299) != 0);
         step();
      end
      ARESETn = 1;
      v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
